// File: rtl/popcount_stream_acc.sv
// Streaming popcount accumulator: sums set (or clear) bits of each word across a packet, result on valid/ready.
// Optional POPCOUNT_SAT_EN macro: clamp the accumulator at its maximum instead of wrapping.
`timescale 1ns/1ps

module popcount_stream_acc #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  din_last,
    input  logic                  cnt_zeros,
    output logic                  din_ready,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  dout_ovf,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int PC_WIDTH = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [DATA_WIDTH-1:0] word;
    logic [PC_WIDTH-1:0]   pc_comb;
    logic [PC_WIDTH-1:0]   s1_pc;
    logic                  s1_valid;
    logic                  s1_last;

    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic                  ovf;
    logic                  ovf_next;
    logic [ACC_WIDTH:0]    sum;

    logic                  in_fire;
    logic                  out_fire;

    assign in_fire  = din_valid & din_ready;
    assign out_fire = dout_valid & dout_ready;

    // Stage-1 bit count of the (optionally inverted) input word
    always_comb begin
        word    = cnt_zeros ? ~din : din;
        pc_comb = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pc_comb = pc_comb + PC_WIDTH'(word[i]);
        end
    end

    // Stage-2 adder; the extra top bit is the carry-out that drives the sticky overflow
    always_comb begin
        sum      = {1'b0, acc} + {{(ACC_WIDTH + 1 - PC_WIDTH){1'b0}}, s1_pc};
        ovf_next = ovf | sum[ACC_WIDTH];
`ifdef POPCOUNT_SAT_EN
        acc_next = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
        acc_next = sum[ACC_WIDTH-1:0];
`endif
    end

    always_comb begin
        state_next = state;
        din_ready  = (state == IDLE) || (state == ACCUM);
        dout_valid = (state == DONE);
        case (state)
            IDLE: begin
                if (in_fire) begin
                    state_next = din_last ? FLUSH : ACCUM;
                end
            end
            ACCUM: begin
                if (in_fire && din_last) begin
                    state_next = FLUSH;
                end
            end
            // Wait here until the last word's count has left stage 1 and landed in acc
            FLUSH: begin
                if (!(s1_valid && s1_last)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            s1_valid <= 1'b0;
            s1_pc    <= '0;
            s1_last  <= 1'b0;
            acc      <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_next;
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_pc   <= pc_comb;
                s1_last <= din_last;
            end
            if (out_fire) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (s1_valid) begin
                acc <= acc_next;
                ovf <= ovf_next;
            end
        end
    end

    assign dout     = acc;
    assign dout_ovf = ovf;

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Self-checking bench for popcount_stream_acc: vector table, hand-written corner sequences, random scoreboard.
// Drives a 16-bit and an 8-bit accumulator instance in lockstep; expectations follow POPCOUNT_SAT_EN.
`timescale 1ns/1ps

module tb_popcount_stream_acc;

    localparam int NUM_PACKETS = 1000;
    localparam int CYCLE_LIMIT = 60000;

    typedef struct {
        logic [15:0] din;
        logic        zeros;
        int          expected;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic        din_valid;
    logic        din_last;
    logic        cnt_zeros;
    logic        dout_ready;

    logic        din_ready;
    logic [15:0] dout;
    logic        dout_ovf;
    logic        dout_valid;

    logic        s_din_ready;
    logic [7:0]  s_dout;
    logic        s_dout_ovf;
    logic        s_dout_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    popcount_stream_acc #(.DATA_WIDTH(16), .ACC_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_last(din_last),
        .cnt_zeros(cnt_zeros), .din_ready(din_ready), .dout(dout), .dout_ovf(dout_ovf),
        .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    popcount_stream_acc #(.DATA_WIDTH(16), .ACC_WIDTH(8)) dut_small (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_last(din_last),
        .cnt_zeros(cnt_zeros), .din_ready(s_din_ready), .dout(s_dout), .dout_ovf(s_dout_ovf),
        .dout_valid(s_dout_valid), .dout_ready(dout_ready)
    );

    // Reference result for a packet whose bit-count sum is 'total' in a 'width'-bit accumulator
    function automatic int model_value(input int total, input int width);
        int max_val;
        max_val = (1 << width) - 1;
        if (total <= max_val) return total;
`ifdef POPCOUNT_SAT_EN
        return max_val;
`else
        return total % (1 << width);
`endif
    endfunction

    function automatic int model_ovf(input int total, input int width);
        return (total > ((1 << width) - 1)) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            n_pass++;
        end
    endtask

    // Present one word and hold it until it fires; returns the number of stalled edges
    task automatic applyStimulus(input logic [15:0] w, input logic l, input logic z, output int stalls);
        logic rdy;
        int   n;
        din       = w;
        din_last  = l;
        cnt_zeros = z;
        din_valid = 1'b1;
        n         = 0;
        forever begin
            @(negedge clk);
            rdy = din_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 50) begin
                checkOutput("din_ready_timeout", 0, 1);
                break;
            end
        end
        din_valid = 1'b0;
        din_last  = 1'b0;
        stalls    = n;
    endtask

    // Count negedges with dout_valid low after the last fire; also count din_ready violations
    task automatic waitResult(output int lat, output int ready_errs);
        int n;
        n          = 0;
        ready_errs = 0;
        forever begin
            @(negedge clk);
            if (dout_valid) break;
            if (din_ready) ready_errs++;
            n++;
            if (n > 50) begin
                checkOutput("dout_valid_timeout", 0, 1);
                break;
            end
        end
        lat = n;
    endtask

    task automatic consumeResult();
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
    endtask

    task automatic runPacket(input logic [15:0] w, input logic z, input int expected, input string name);
        int st, lat, rerr;
        applyStimulus(w, 1'b1, z, st);
        waitResult(lat, rerr);
        checkOutput({name, "_dout"}, int'(dout), expected);
        checkOutput({name, "_ovf"}, int'(dout_ovf), 0);
        consumeResult();
    endtask

    initial begin
        vec_t vecs[9];
        int   st, lat, rerr, total, stall_sum, errs;
        logic [15:0] held;
        logic [15:0] words4[4];
        logic        zeros4[4];

        vecs[0] = '{16'hA5A5, 1'b0, 8};
        vecs[1] = '{16'hFFFF, 1'b0, 16};
        vecs[2] = '{16'h0000, 1'b0, 0};
        vecs[3] = '{16'h0000, 1'b1, 16};
        vecs[4] = '{16'hFFFF, 1'b1, 0};
        vecs[5] = '{16'h0001, 1'b0, 1};
        vecs[6] = '{16'h8000, 1'b1, 15};
        vecs[7] = '{16'h1234, 1'b0, 5};
        vecs[8] = '{16'hF0F0, 1'b1, 8};

        reset      = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        cnt_zeros  = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_din_ready", int'(din_ready), 1);
        checkOutput("reset_dout_valid", int'(dout_valid), 0);
        checkOutput("reset_dout", int'(dout), 0);
        checkOutput("reset_dout_ovf", int'(dout_ovf), 0);
        checkOutput("reset_small_din_ready", int'(s_din_ready), 1);
        @(posedge clk);
        #1;

        $display("[TB] single-word vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].din, 1'b1, vecs[i].zeros, st);
            waitResult(lat, rerr);
            checkOutput($sformatf("vec%0d_latency", i), lat, 2);
            checkOutput($sformatf("vec%0d_ready_low", i), rerr, 0);
            checkOutput($sformatf("vec%0d_dout", i), int'(dout), vecs[i].expected);
            checkOutput($sformatf("vec%0d_ovf", i), int'(dout_ovf), 0);
            consumeResult();
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ready_after", i), int'(din_ready), 1);
            checkOutput($sformatf("vec%0d_valid_after", i), int'(dout_valid), 0);
            @(posedge clk);
            #1;
        end

        $display("[TB] four-word back-to-back packet");
        words4    = '{16'hFFFF, 16'h0001, 16'h0000, 16'h8000};
        zeros4    = '{1'b0, 1'b0, 1'b1, 1'b0};
        stall_sum = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(words4[i], (i == 3), zeros4[i], st);
            stall_sum += st;
        end
        checkOutput("pkt4_stalls", stall_sum, 0);
        waitResult(lat, rerr);
        checkOutput("pkt4_latency", lat, 2);
        checkOutput("pkt4_dout", int'(dout), 34);
        checkOutput("pkt4_ovf", int'(dout_ovf), 0);
        checkOutput("pkt4_small_dout", int'(s_dout), 34);
        consumeResult();

        $display("[TB] overflow packet of 17 full words");
        total = 0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(16'hFFFF, (i == 16), 1'b0, st);
            total += $countones(16'hFFFF);
        end
        waitResult(lat, rerr);
        checkOutput("ovf_dout16", int'(dout), model_value(total, 16));
        checkOutput("ovf_ovf16", int'(dout_ovf), model_ovf(total, 16));
        checkOutput("ovf_small_valid", int'(s_dout_valid), 1);
        checkOutput("ovf_small_dout", int'(s_dout), model_value(total, 8));
        checkOutput("ovf_small_ovf", int'(s_dout_ovf), model_ovf(total, 8));
        consumeResult();
        runPacket(16'h0101, 1'b0, 2, "after_ovf");
        checkOutput("after_ovf_small_ovf", int'(s_dout_ovf), 0);

        $display("[TB] backpressure in DONE");
        applyStimulus(16'h00FF, 1'b0, 1'b0, st);
        applyStimulus(16'h0F00, 1'b1, 1'b0, st);
        waitResult(lat, rerr);
        held      = dout;
        din       = 16'hFFFF;
        din_last  = 1'b0;
        din_valid = 1'b1;
        errs      = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dout !== held || dout_ovf !== 1'b0 || dout_valid !== 1'b1 || din_ready !== 1'b0) errs++;
        end
        checkOutput("bp_stable_errs", errs, 0);
        checkOutput("bp_dout", int'(dout), 12);
        consumeResult();
        din_valid = 1'b0;
        runPacket(16'h000F, 1'b0, 4, "bp_next");

        $display("[TB] reset during a packet");
        applyStimulus(16'hFFFF, 1'b0, 1'b0, st);
        applyStimulus(16'h00FF, 1'b0, 1'b0, st);
        din       = 16'h0F0F;
        din_valid = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_din_ready", int'(din_ready), 1);
        checkOutput("rst_dout_valid", int'(dout_valid), 0);
        checkOutput("rst_dout", int'(dout), 0);
        checkOutput("rst_dout_ovf", int'(dout_ovf), 0);
        @(posedge clk);
        #1;
        runPacket(16'h0003, 1'b0, 2, "rst_next");

        $display("[TB] random traffic, %0d packets", NUM_PACKETS);
        begin
            int got;
            got = 0;
            fork
                begin
                    int cyc;
                    cyc = 0;
                    for (int p = 0; p < NUM_PACKETS && cyc < CYCLE_LIMIT; p++) begin
                        logic [15:0] pw[8];
                        logic        pz[8];
                        int          len, idx, ptotal;
                        len    = $urandom_range(1, 8);
                        ptotal = 0;
                        for (int j = 0; j < len; j++) begin
                            pw[j] = 16'($urandom);
                            pz[j] = 1'($urandom_range(0, 1));
                            ptotal += pz[j] ? (16 - $countones(pw[j])) : $countones(pw[j]);
                        end
                        idx = 0;
                        while (idx < len && cyc < CYCLE_LIMIT) begin
                            din       = pw[idx];
                            cnt_zeros = pz[idx];
                            din_last  = (idx == len - 1);
                            din_valid = ($urandom_range(0, 3) != 0);
                            @(negedge clk);
                            if (din_valid && din_ready) begin
                                idx++;
                                if (idx == len) exp_q.push_back(ptotal);
                            end
                            @(posedge clk);
                            #1;
                            cyc++;
                        end
                    end
                    din_valid = 1'b0;
                    din_last  = 1'b0;
                end
                begin
                    int ccyc, e;
                    ccyc = 0;
                    while (got < NUM_PACKETS && ccyc < CYCLE_LIMIT) begin
                        dout_ready = 1'($urandom_range(0, 1));
                        @(negedge clk);
                        if (dout_valid && dout_ready) begin
                            if (exp_q.size() == 0) begin
                                checkOutput("rand_unexpected_result", 1, 0);
                            end else begin
                                e = exp_q.pop_front();
                                checkOutput($sformatf("rand%0d_dout", got), int'(dout), model_value(e, 16));
                                checkOutput($sformatf("rand%0d_ovf", got), int'(dout_ovf), model_ovf(e, 16));
                            end
                            got++;
                        end
                        @(posedge clk);
                        #1;
                        ccyc++;
                    end
                    dout_ready = 1'b0;
                end
            join
            checkOutput("rand_results_received", got, NUM_PACKETS);
            checkOutput("rand_queue_empty", exp_q.size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
